// File: rtl/spi_burst_ram_if.sv
// SPI pin bundle for spi_burst_ram: the memory sits on the slave side, the host drives the master side.
// Pure wiring with no latency; there is no flow control beyond SS_n framing.
interface spi_burst_ram_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic frame_err;

  modport slave  (input SS_n, input MOSI, output MISO, output frame_err);
  modport master (output SS_n, output MOSI, input MISO, input frame_err);
endinterface

// File: rtl/spi_burst_ram.sv
// SPI slave fronting a word memory with burst read/write, pointer auto-increment and wrap.
// Write lands on the edge that completes the word; each read word follows a 1-cycle turnaround; no backpressure.
module spi_burst_ram #(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 1
) (
  input logic            clk,
  input logic            rst_n,
  spi_burst_ram_if.slave spi
);
  // ADDR_SIZE and DATA_WIDTH are expected to be at least 3 bits.
  localparam int SW = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
  localparam int CW = $clog2(SW);
  localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CW-1:0]      LP_ADDR_LAST = CW'(ADDR_SIZE - 1);
  localparam logic [CW-1:0]      LP_DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]      LP_DATA_PEN  = CW'(DATA_WIDTH - 2);
  localparam logic [ADDR_SIZE:0] LP_DEPTH     = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] LP_PTR_LAST  = (ADDR_SIZE+1)'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, OPC, ADDR, WDATA, RTURN, RDATA, WAIT} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_armed, r_opc_hi, r_frame_err;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [SW-2:0]         r_sh;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [ADDR_SIZE-1:0]  r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_err, w_mem_we, w_ld_ptr, w_inc_wr, w_inc_rd, w_tx_load;
  logic                  w_wr_in_rng, w_rd_in_rng;
  logic [ADDR_SIZE-1:0]  w_addr_in, w_wr_nxt, w_rd_nxt;
  logic [DATA_WIDTH-1:0] w_wdata, w_rd_word;

  // Bit sampled on this edge completes the field together with the shift history.
  assign w_addr_in   = {r_sh[ADDR_SIZE-2:0], spi.MOSI};
  assign w_wdata     = {r_sh[DATA_WIDTH-2:0], spi.MOSI};
  assign w_wr_in_rng = ({1'b0, r_wr_ptr} < LP_DEPTH);
  assign w_rd_in_rng = ({1'b0, r_rd_ptr} < LP_DEPTH);
  assign w_wr_nxt    = ({1'b0, r_wr_ptr} >= LP_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt    = ({1'b0, r_rd_ptr} >= LP_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
  assign w_rd_word   = w_rd_in_rng ? r_mem[r_rd_ptr[MW-1:0]] : '0;

  assign spi.MISO      = (r_state == RDATA) & r_tx[DATA_WIDTH-1];
  assign spi.frame_err = r_frame_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err       = 1'b0;
    w_mem_we    = 1'b0;
    w_ld_ptr    = 1'b0;
    w_inc_wr    = 1'b0;
    w_inc_rd    = 1'b0;
    w_tx_load   = 1'b0;
    if (spi.SS_n) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      case (r_state)
        OPC:         w_err = 1'b1;
        ADDR, WDATA: w_err = (r_cnt != '0);
        default:     w_err = 1'b0;
      endcase
    end else begin
      case (r_state)
        IDLE: if (r_armed) w_state_nxt = OPC;
        OPC: begin
          w_cnt_nxt = '0;
          case ({r_opc_hi, spi.MOSI})
            2'b01:   w_state_nxt = WDATA;
            2'b11:   w_state_nxt = RTURN;
            default: w_state_nxt = ADDR;
          endcase
        end
        ADDR: begin
          if (r_cnt == LP_ADDR_LAST) begin
            w_ld_ptr    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = WAIT;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        WDATA: begin
          if (r_cnt == LP_DATA_LAST) begin
            w_mem_we  = 1'b1;
            w_inc_wr  = (AUTO_INC != 0);
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        RTURN: begin
          w_tx_load   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = RDATA;
        end
        RDATA: begin
          if (r_cnt == LP_DATA_LAST) begin
            w_state_nxt = RTURN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
            // This edge drives the last bit of the word.
            w_inc_rd  = (AUTO_INC != 0) && (r_cnt == LP_DATA_PEN);
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_armed     <= 1'b0;
      r_opc_hi    <= 1'b0;
      r_frame_err <= 1'b0;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_tx        <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_frame_err <= w_err;
      r_sh        <= {r_sh[SW-3:0], spi.MOSI};
      // A frame is only accepted once SS_n has been seen high after reset.
      if (spi.SS_n) r_armed <= 1'b1;
      if (r_state == IDLE) r_opc_hi <= spi.MOSI;
      if (w_ld_ptr && !r_opc_hi) r_wr_ptr <= w_addr_in;
      else if (w_inc_wr)         r_wr_ptr <= w_wr_nxt;
      if (w_ld_ptr && r_opc_hi)  r_rd_ptr <= w_addr_in;
      else if (w_inc_rd)         r_rd_ptr <= w_rd_nxt;
      if (w_tx_load)             r_tx <= w_rd_word;
      else if (r_state == RDATA) r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we && w_wr_in_rng) r_mem[r_wr_ptr[MW-1:0]] <= w_wdata;
  end
endmodule

// File: tb/tb_spi_burst_ram.sv
// Drives one SPI stream into three configurations (256/inc, 200/inc, 256/hold) and checks each
// against a frame-level model of memory contents and pointers.
module tb_spi_burst_ram;
  localparam int DW = 8;
  localparam int AS = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ss_n  = 1'b1;
  logic mosi  = 1'b0;
  logic [2:0] miso, ferr;

  always #5 clk = ~clk;

  spi_burst_ram_if ifa ();
  spi_burst_ram_if ifb ();
  spi_burst_ram_if ifc ();

  assign ifa.SS_n = ss_n;
  assign ifb.SS_n = ss_n;
  assign ifc.SS_n = ss_n;
  assign ifa.MOSI = mosi;
  assign ifb.MOSI = mosi;
  assign ifc.MOSI = mosi;
  assign miso = {ifc.MISO, ifb.MISO, ifa.MISO};
  assign ferr = {ifc.frame_err, ifb.frame_err, ifa.frame_err};

  spi_burst_ram #(.ADDR_SIZE(AS), .DATA_WIDTH(DW), .MEM_DEPTH(256), .AUTO_INC(1))
    u_a (.clk(clk), .rst_n(rst_n), .spi(ifa));
  spi_burst_ram #(.ADDR_SIZE(AS), .DATA_WIDTH(DW), .MEM_DEPTH(200), .AUTO_INC(1))
    u_b (.clk(clk), .rst_n(rst_n), .spi(ifb));
  spi_burst_ram #(.ADDR_SIZE(AS), .DATA_WIDTH(DW), .MEM_DEPTH(256), .AUTO_INC(0))
    u_c (.clk(clk), .rst_n(rst_n), .spi(ifc));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-configuration memory image and pointers.
  logic [DW-1:0] m_mem [3][256];
  int m_wp [3];
  int m_rp [3];
  logic tx [$];

  function automatic int depth_of(int c);
    return (c == 1) ? 200 : 256;
  endfunction

  function automatic int step(int c, int p);
    if (c == 2) return p;
    return (p >= depth_of(c) - 1) ? 0 : p + 1;
  endfunction

  function automatic logic [DW-1:0] peek(int c, int p);
    return (p < depth_of(c)) ? m_mem[c][p] : '0;
  endfunction

  function automatic logic [31:0] bits_at(int s, int n);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = {v[30:0], tx[s+i]};
    return v;
  endfunction

  // MISO after edge e of a read frame: word k occupies DW edges starting at 3+k*(DW+1), then one zero.
  function automatic logic exp_miso(int c, int opc, int e);
    int p, k, j, a;
    logic [DW-1:0] w;
    if (opc != 3 || e < 3) return 1'b0;
    p = e - 3;
    k = p / (DW + 1);
    j = p % (DW + 1);
    if (j == DW) return 1'b0;
    a = m_rp[c];
    for (int i = 0; i < k; i++) a = step(c, a);
    w = peek(c, a);
    return w[DW-1-j];
  endfunction

  task automatic model_end(input int c, input int len, input int opc, output logic err);
    int n;
    err = 1'b0;
    if (len == 1) begin
      err = 1'b1;
    end else if (opc == 0 || opc == 2) begin
      if (len >= 2 + AS) begin
        if (opc == 0) m_wp[c] = int'(bits_at(2, AS));
        else          m_rp[c] = int'(bits_at(2, AS));
      end else if (len > 2) begin
        err = 1'b1;
      end
    end else if (opc == 1) begin
      n = (len - 2) / DW;
      for (int k = 0; k < n; k++) begin
        if (m_wp[c] < depth_of(c)) m_mem[c][m_wp[c]] = bits_at(2 + k*DW, DW)[DW-1:0];
        m_wp[c] = step(c, m_wp[c]);
      end
      err = ((len - 2) % DW) != 0;
    end else begin
      n = (len >= 2 + DW) ? (len - 2 - DW) / (DW + 1) + 1 : 0;
      for (int k = 0; k < n; k++) m_rp[c] = step(c, m_rp[c]);
    end
  endtask

  task automatic push(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tx.push_back(v[i]);
  endtask

  // Called just after a falling edge; plays tx as one frame and checks every cycle.
  task automatic run_frame();
    int len = tx.size();
    int opc = (len >= 2) ? int'({tx[0], tx[1]}) : -1;
    logic err;
    for (int e = 1; e <= len; e++) begin
      ss_n = 1'b0;
      mosi = tx[e-1];
      @(negedge clk);
      for (int c = 0; c < 3; c++)
        check_eq($sformatf("miso cfg%0d opc%0d edge%0d", c, opc, e), miso[c], exp_miso(c, opc, e));
    end
    ss_n = 1'b1;
    mosi = 1'($urandom);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      model_end(c, len, opc, err);
      check_eq($sformatf("frame_err cfg%0d opc%0d len%0d", c, opc, len), ferr[c], err);
      check_eq($sformatf("miso_idle cfg%0d", c), miso[c], 1'b0);
    end
    @(negedge clk);
    for (int c = 0; c < 3; c++)
      check_eq($sformatf("frame_err_drop cfg%0d", c), ferr[c], 1'b0);
    tx.delete();
  endtask

  task automatic wr_addr(input logic [7:0] a);
    push(0, 2); push(a, AS); run_frame();
  endtask

  task automatic rd_addr(input logic [7:0] a);
    push(2, 2); push(a, AS); run_frame();
  endtask

  task automatic rd_data(input int n);
    push(3, 2); push($urandom, n * (DW + 1)); run_frame();
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 8'hFF;
      1:       return 8'hC7;
      2:       return 8'hC8;
      3:       return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    for (int c = 0; c < 3; c++) begin
      m_wp[c] = 0;
      m_rp[c] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("reset_miso cfg%0d", c), miso[c], 1'b0);
      check_eq($sformatf("reset_ferr cfg%0d", c), ferr[c], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 256; a++) begin
      wr_addr(8'(a));
      push(1, 2); push($urandom, DW); run_frame();
    end

    wr_addr(8'h10);
    push(1, 2); push(8'hA5, DW); push(8'h3C, DW); run_frame();
    rd_addr(8'h10);
    rd_data(2);

    wr_addr(8'hFF);
    push(1, 2); push(8'h11, DW); push(8'h22, DW); run_frame();
    push(1, 2); push(8'h33, DW); run_frame();
    rd_addr(8'hFF);
    rd_data(3);

    wr_addr(8'hD0);
    push(1, 2); push(8'h55, DW); run_frame();
    rd_addr(8'hD0);
    rd_data(2);

    wr_addr(8'h20);
    push(1, 2); push(5'h1B, 5); run_frame();
    push(1, 2); push(8'h77, DW); run_frame();
    rd_addr(8'h20);
    rd_data(2);

    rd_addr(8'h05);
    rd_data(3);

    // Reset in the middle of a read burst, released while SS_n is still low.
    rd_addr(8'h40);
    for (int e = 1; e <= 7; e++) begin
      ss_n = 1'b0;
      mosi = (e <= 2);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("midreset_miso cfg%0d", c), miso[c], 1'b0);
      check_eq($sformatf("midreset_ferr cfg%0d", c), ferr[c], 1'b0);
      m_wp[c] = 0;
      m_rp[c] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      mosi = (e == 2) ? 1'b1 : (e == 1) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        check_eq($sformatf("ignored_miso cfg%0d edge%0d", c, e), miso[c], 1'b0);
        check_eq($sformatf("ignored_ferr cfg%0d edge%0d", c, e), ferr[c], 1'b0);
      end
    end
    ss_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 3; c++)
      check_eq($sformatf("ignored_end_ferr cfg%0d", c), ferr[c], 1'b0);
    rd_data(2);
    push(1, 2); push($urandom, DW); run_frame();
    rd_addr(8'h00);
    rd_data(1);

    for (int f = 0; f < 150; f++) begin
      int opc = $urandom_range(0, 3);
      int r   = $urandom_range(0, 9);
      int n   = $urandom_range(1, 3);
      if (r == 0) begin
        tx.push_back(1'($urandom));
      end else begin
        push(opc, 2);
        if (opc == 0 || opc == 2) begin
          if (r == 1) push($urandom, $urandom_range(1, 7));
          else begin
            push(pick_addr(), AS);
            push($urandom, $urandom_range(0, 3));
          end
        end else if (opc == 1) begin
          for (int k = 0; k < n; k++) push($urandom, DW);
          if (r == 1) push($urandom, $urandom_range(1, 7));
        end else begin
          push($urandom, n * (DW + 1) + $urandom_range(0, 8));
        end
      end
      run_frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_burst_ram.md
Name: spi_burst_ram

Overview:
- Integrated SPI slave and single-port memory, the parametrised successor to the fixed 8-bit SPI+RAM pair.
- Generalises address width, data width and depth independently.
- Adds burst streaming with address auto-increment, out-of-range protection and frame-error reporting.
- Sits directly on the external SPI pins as a self-contained register/scratch memory.

Parameters:
ADDR_SIZE  8  width of address payload and address pointers
DATA_WIDTH  8  width of one memory word and one data payload
MEM_DEPTH  256  number of words; must be <= 2**ADDR_SIZE
AUTO_INC  1  1: pointer increments after each data word; 0: pointer holds

Ports:
clk  input  1  system clock, all sampling on rising edge
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  slave select, active low, frames a transaction
MOSI  input  1  serial data in, MSB first
MISO  output  1  serial data out, MSB first
frame_err  output  1  one-cycle pulse when a frame ends on a partial field

Behaviour:
- Reset is asynchronous and active-low on rst_n. During reset: MISO=0, frame_err=0, wr_ptr=0, rd_ptr=0, FSM=IDLE.
- Memory contents are not reset.
- After reset release, if SS_n is already low, the block waits in IDLE until SS_n is sampled high before accepting a frame. No mid-frame sync.
- Edge numbering: edge 1 is the first rising clk edge with SS_n sampled low; MOSI is sampled on every edge while SS_n is low.
- Opcode: 2 bits, MSB first, captured on edges 1-2.
  - 00 WR_ADDR: next ADDR_SIZE bits load wr_ptr.
  - 10 RD_ADDR: next ADDR_SIZE bits load rd_ptr.
  - 01 WR_DATA: each following DATA_WIDTH bits form a word written to mem[wr_ptr].
  - 11 RD_DATA: stream words from mem[rd_ptr].
- FSM states: IDLE, OPC, ADDR, WDATA, RTURN, RDATA.
  - IDLE->OPC on SS_n low.
  - OPC->ADDR/WDATA/RTURN after 2 opcode bits.
  - ADDR->IDLE_WAIT after the address is loaded. Further bits are ignored until SS_n goes high.
  - WDATA loops: words are back-to-back, no gap.
  - RTURN->RDATA->RTURN loops.
- Write:
  - Word k of a burst completes on edge 2+(k+1)*DATA_WIDTH.
  - mem is written on that edge; the data is readable by any later read frame.
  - wr_ptr then increments if AUTO_INC=1.
- Read:
  - Each word is preceded by one turnaround edge (RTURN): mem[rd_ptr] is loaded into the shift register and MISO=0 during the turnaround cycle.
  - MSB of word k is driven after edge 3+k*(DATA_WIDTH+1). Remaining bits follow on successive edges.
  - rd_ptr increments (AUTO_INC=1) on the edge that drives the last bit.
- Pointer wrap: a pointer at MEM_DEPTH-1 increments to 0. This also applies when MEM_DEPTH is not a power of two.
- Out of range (pointer >= MEM_DEPTH):
  - Writes are dropped.
  - Reads shift out all zeros.
  - The pointer still increments and then wraps to 0.
- MISO is 0 whenever the FSM is not in RDATA.
- SS_n high from any state: FSM returns to IDLE on that edge.
  - If a field (opcode, address or data word) was partially received, frame_err pulses for 1 cycle, the partial word is discarded and no memory write occurs.
  - Partial read words raise no error.
- Pointers persist across frames. Only reset or an address command changes them other than auto-increment.
- wr_ptr and rd_ptr are independent. Read and write never happen in the same cycle; the protocol is half duplex.

Test Plan:
- Reset, then WR_ADDR 0x10, then WR_DATA burst 0xA5, 0x3C in one frame; RD_ADDR 0x10, RD_DATA for 2 words -> MISO streams 0xA5 then 0x3C, with a 1-cycle turnaround before each.
- WR_ADDR 0xFF, WR_DATA burst 0x11, 0x22 (MEM_DEPTH=256) -> mem[0xFF]=0x11, mem[0x00]=0x22, wr_ptr=0x01.
- With MEM_DEPTH=200: WR_ADDR 0xD0, WR_DATA 0x55; read 0xD0 -> MISO all zeros, no memory word altered.
- WR_DATA frame with SS_n raised after 5 of 8 data bits -> frame_err high exactly 1 cycle, target word unchanged, wr_ptr unchanged.
- Assert rst_n low mid RD_DATA, release with SS_n still low -> MISO=0, no response until SS_n high then low; pointers read back as 0.
- AUTO_INC=0: RD_ADDR 0x05, RD_DATA 3 words -> mem[0x05] is repeated three times.
